// File: rtl/mont_exp_seq_pkg.sv
// Shared types for the modular-exponentiation sequencer: FSM states,
// destination-register select and multiply-phase encodings.
package mont_exp_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CONV_BASE = 3'd1,
        CONV_ONE  = 3'd2,
        SQUARE    = 3'd3,
        MULT      = 3'd4,
        EXIT      = 3'd5,
        DRAIN     = 3'd6
    } state_e;

    // Which working register receives the multiplier result.
    typedef enum logic {
        DST_ACC    = 1'b0,
        DST_BASE_M = 1'b1
    } dest_e;

    // Each multiply is one ISSUE cycle followed by a WAIT phase.
    typedef enum logic {
        PH_ISSUE = 1'b0,
        PH_WAIT  = 1'b1
    } phase_e;

    // Only the base conversion writes base_m; every other op writes acc.
    function automatic dest_e dest_of(state_e s);
        return (s == CONV_BASE) ? DST_BASE_M : DST_ACC;
    endfunction

endpackage

// File: rtl/mont_exp_seq_exp_bit_scanner.sv
// Exponent bit scanner: holds the exponent MSB-aligned in a shift register
// and counts scanned bits, so the FSM only sees cur_bit / last_bit.
module exp_bit_scanner #(
    parameter int NBITS = 2048,
    parameter int SW    = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [NBITS-1:0] exp,
    input  logic [SW-1:0]    size,
    input  logic             advance,
    output logic             cur_bit,
    output logic             last_bit,
    output logic             zero_len
);

    localparam logic [SW-1:0] NB = SW'(NBITS);

    logic [NBITS-1:0] exp_sh;
    logic [SW-1:0]    bit_cnt;
    logic [SW-1:0]    size_q;

    // Load aligns bit size-1 to the top; advance shifts the next bit up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_sh  <= '0;
            bit_cnt <= '0;
            size_q  <= '0;
        end else if (load) begin
            exp_sh  <= exp << (NB - size);
            bit_cnt <= '0;
            size_q  <= size;
        end else if (advance) begin
            exp_sh  <= exp_sh << 1;
            bit_cnt <= bit_cnt + SW'(1);
        end
    end

    assign cur_bit  = exp_sh[NBITS-1];
    assign last_bit = (bit_cnt + SW'(1)) >= size_q;
    assign zero_len = (size_q == '0);

endmodule

// File: rtl/mont_exp_seq.sv
// Modular exponentiation sequencer around one shared Montgomery multiplier:
// convert into the Montgomery domain, left-to-right square-and-multiply,
// convert back out.
// Handshake with the multiplier: mm_enable_p is a one-cycle request with
// mm_a/mm_b valid that cycle; the multiplier answers later with a one-cycle
// mm_done_p carrying mm_y. Only one request is ever outstanding.
module mont_exp_seq
    import mont_exp_pkg::*;
#(
    parameter int NBITS = 2048,
    parameter int SW    = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_p,
    input  logic             abort_p,
    input  logic [NBITS-1:0] base,
    input  logic [NBITS-1:0] exp,
    input  logic [SW-1:0]    exp_size,
    input  logic [NBITS-1:0] m,
    input  logic [SW-1:0]    m_size,
    input  logic [NBITS-1:0] r2,
    output logic             busy,
    output logic [NBITS-1:0] y,
    output logic             done_irq_p,
    output logic             mm_enable_p,
    output logic [NBITS-1:0] mm_a,
    output logic [NBITS-1:0] mm_b,
    output logic [NBITS-1:0] mm_m,
    output logic [NBITS-1:0] mm_m_size,
    input  logic [NBITS-1:0] mm_y,
    input  logic             mm_done_p
);

    localparam logic [SW-1:0]    NB  = SW'(NBITS);
    localparam logic [NBITS-1:0] ONE = NBITS'(1);

    state_e state, state_n;
    phase_e phase, phase_n;

    logic [NBITS-1:0] base_q, m_q, r2_q, acc, base_m;
    logic [SW-1:0]    m_size_q;
    logic [SW-1:0]    size_clamped;
    logic             load, advance, capture, finish;
    logic             cur_bit, last_bit, zero_len;
    logic             op_state;

    assign size_clamped = (exp_size > NB) ? NB : exp_size;
    assign op_state     = (state != IDLE) && (state != DRAIN);

    exp_bit_scanner #(.NBITS(NBITS), .SW(SW)) u_scan (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .exp      (exp),
        .size     (size_clamped),
        .advance  (advance),
        .cur_bit  (cur_bit),
        .last_bit (last_bit),
        .zero_len (zero_len)
    );

    // FSM state and multiply-phase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            phase <= PH_ISSUE;
        end else begin
            state <= state_n;
            phase <= phase_n;
        end
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        state_n = state;
        phase_n = phase;
        load    = 1'b0;
        advance = 1'b0;
        capture = 1'b0;
        finish  = 1'b0;
        case (state)
            IDLE: begin
                if (start_p) begin
                    load    = 1'b1;
                    state_n = CONV_BASE;
                    phase_n = PH_ISSUE;
                end
            end
            DRAIN: begin
                if (mm_done_p) state_n = IDLE;
            end
            default: begin
                if (abort_p) begin
                    // No request in flight (issue suppressed) or it ends now.
                    if (phase == PH_ISSUE || mm_done_p) state_n = IDLE;
                    else                                state_n = DRAIN;
                end else if (phase == PH_ISSUE) begin
                    phase_n = PH_WAIT;
                end else if (mm_done_p) begin
                    capture = 1'b1;
                    phase_n = PH_ISSUE;
                    case (state)
                        CONV_BASE: state_n = CONV_ONE;
                        CONV_ONE:  state_n = zero_len ? EXIT : SQUARE;
                        SQUARE: begin
                            if (cur_bit) begin
                                state_n = MULT;
                            end else begin
                                advance = 1'b1;
                                state_n = last_bit ? EXIT : SQUARE;
                            end
                        end
                        MULT: begin
                            advance = 1'b1;
                            state_n = last_bit ? EXIT : SQUARE;
                        end
                        EXIT: begin
                            finish  = 1'b1;
                            state_n = IDLE;
                        end
                        default: state_n = IDLE;
                    endcase
                end
            end
        endcase
    end

    // Operand latches, working registers, result and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q     <= '0;
            m_q        <= '0;
            r2_q       <= '0;
            m_size_q   <= '0;
            acc        <= '0;
            base_m     <= '0;
            y          <= '0;
            done_irq_p <= 1'b0;
        end else begin
            done_irq_p <= finish;
            if (load) begin
                base_q   <= base;
                m_q      <= m;
                r2_q     <= r2;
                m_size_q <= m_size;
            end
            if (capture) begin
                if (dest_of(state) == DST_BASE_M) base_m <= mm_y;
                else                              acc    <= mm_y;
            end
            if (finish) y <= mm_y;
        end
    end

    // Operand select per operation; held for the whole op.
    always_comb begin
        mm_a = '0;
        mm_b = '0;
        case (state)
            CONV_BASE: begin mm_a = base_q; mm_b = r2_q;   end
            CONV_ONE:  begin mm_a = ONE;    mm_b = r2_q;   end
            SQUARE:    begin mm_a = acc;    mm_b = acc;    end
            MULT:      begin mm_a = acc;    mm_b = base_m; end
            EXIT:      begin mm_a = acc;    mm_b = ONE;    end
            default:   begin mm_a = '0;     mm_b = '0;     end
        endcase
    end

    assign mm_enable_p = op_state && (phase == PH_ISSUE) && !abort_p;
    assign mm_m        = m_q;
    assign mm_m_size   = NBITS'(m_size_q);
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_mont_exp_seq.sv
// Directed bench for mont_exp_seq with a behavioural Montgomery multiplier.
module tb_mont_exp_seq;

    localparam int NBITS = 32;
    localparam int SW    = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start_p, abort_p;
    logic [NBITS-1:0] base, exp, m, r2;
    logic [SW-1:0]    exp_size, m_size;
    logic             busy, done_irq_p, mm_enable_p, mm_done_p;
    logic [NBITS-1:0] y, mm_a, mm_b, mm_m, mm_m_size, mm_y;

    int total = 0;
    int bad   = 0;
    int enable_cnt = 0;
    int done_seen  = 0;

    // clock / reset
    always #5 clk = ~clk;

    mont_exp_seq #(.NBITS(NBITS), .SW(SW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_p     (start_p),
        .abort_p     (abort_p),
        .base        (base),
        .exp         (exp),
        .exp_size    (exp_size),
        .m           (m),
        .m_size      (m_size),
        .r2          (r2),
        .busy        (busy),
        .y           (y),
        .done_irq_p  (done_irq_p),
        .mm_enable_p (mm_enable_p),
        .mm_a        (mm_a),
        .mm_b        (mm_b),
        .mm_m        (mm_m),
        .mm_m_size   (mm_m_size),
        .mm_y        (mm_y),
        .mm_done_p   (mm_done_p)
    );

    // a*b*2^-k mod m by bit-serial reduction
    function automatic logic [NBITS-1:0] mont_ref(input logic [NBITS-1:0] a,
                                                  input logic [NBITS-1:0] b,
                                                  input logic [NBITS-1:0] mod,
                                                  input logic [NBITS-1:0] k);
        longint unsigned t;
        t = longint'(a) * longint'(b);
        for (int i = 0; i < int'(k); i++) begin
            if (t[0]) t = t + longint'(mod);
            t = t >> 1;
        end
        if (t >= longint'(mod)) t = t - longint'(mod);
        return t[NBITS-1:0];
    endfunction

    // plain square-and-multiply, no Montgomery arithmetic
    function automatic logic [NBITS-1:0] pow_ref(input longint unsigned b,
                                                 input longint unsigned e,
                                                 input longint unsigned mod,
                                                 input int n);
        longint unsigned r;
        r = 1 % mod;
        for (int i = n - 1; i >= 0; i--) begin
            r = (r * r) % mod;
            if (e[i]) r = (r * b) % mod;
        end
        return r[NBITS-1:0];
    endfunction

    // behavioural multiplier: fixed latency, one-cycle done pulse
    logic [NBITS-1:0] res_q;
    logic             pend;
    int               dly;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm_done_p <= 1'b0;
            mm_y      <= '0;
            pend      <= 1'b0;
            dly       <= 0;
        end else begin
            mm_done_p <= 1'b0;
            if (mm_enable_p) begin
                res_q      <= mont_ref(mm_a, mm_b, mm_m, mm_m_size);
                pend       <= 1'b1;
                dly        <= 4;
                enable_cnt <= enable_cnt + 1;
            end else if (pend) begin
                if (dly == 1) begin
                    pend      <= 1'b0;
                    mm_done_p <= 1'b1;
                    mm_y      <= res_q;
                end
                dly <= dly - 1;
            end
        end
    end

    always @(negedge clk) if (done_irq_p) done_seen++;

    // scoreboard check
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // driver: present operands and pulse start_p
    task automatic begin_run(input logic [NBITS-1:0] b, input logic [NBITS-1:0] e,
                             input logic [SW-1:0] esz, input logic [NBITS-1:0] mod,
                             input logic [SW-1:0] msz, input logic [NBITS-1:0] rr,
                             input logic with_abort);
        @(negedge clk);
        base = b; exp = e; exp_size = esz; m = mod; m_size = msz; r2 = rr;
        start_p = 1'b1;
        abort_p = with_abort;
        @(negedge clk);
        start_p = 1'b0;
        abort_p = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(input string tag, input logic [NBITS-1:0] exp_y,
                             input int exp_ops, input int pre);
        int n;
        n = 0;
        while (!done_irq_p && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, 64'(done_irq_p), 64'd1);
        chk({tag, "_y"}, 64'(y), 64'(exp_y));
        chk({tag, "_busy_low"}, 64'(busy), 64'd0);
        chk({tag, "_ops"}, 64'(enable_cnt - pre), 64'(exp_ops));
        @(negedge clk);
        chk({tag, "_done_width"}, 64'(done_irq_p), 64'd0);
    endtask

    logic [NBITS-1:0] big_r2, big_y;
    int pre, ds, n;

    initial begin
        rst_n = 1'b0; start_p = 1'b0; abort_p = 1'b0;
        base = '0; exp = '0; exp_size = '0; m = '0; m_size = '0; r2 = '0;
        big_r2 = 32'((64'd1 << 34) % 64'd72639);
        big_y  = pow_ref(5792, 1229, 72639, 11);
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_y", 64'(y), 64'd0);
        chk("rst_done", 64'(done_irq_p), 64'd0);
        chk("rst_en", 64'(mm_enable_p), 64'd0);
        chk("rst_mm_a", 64'(mm_a), 64'd0);
        chk("rst_mm_m", 64'(mm_m), 64'd0);
        chk("rst_mm_m_size", 64'(mm_m_size), 64'd0);
        rst_n = 1'b1;

        // 2^10 mod 13 = 10, 3+4+2 ops
        pre = enable_cnt; ds = done_seen;
        begin_run(2, 10, 4, 13, 4, 9, 1'b0);
        chk("t1_mm_m_size", 64'(mm_m_size), 64'd4);
        wait_done("t1", 10, 9, pre);
        chk("t1_single_pulse", 64'(done_seen - ds), 64'd1);

        // exp_size 0 -> 1 mod 13
        pre = enable_cnt;
        begin_run(2, 0, 0, 13, 4, 9, 1'b0);
        wait_done("t2", 1, 3, pre);

        // 2^1 mod 13, start and abort together: start wins
        pre = enable_cnt;
        begin_run(2, 1, 1, 13, 4, 9, 1'b1);
        wait_done("t3", 2, 5, pre);

        // m = 1 -> 0
        pre = enable_cnt;
        begin_run(0, 0, 0, 1, 1, 0, 1'b0);
        wait_done("t4", 0, 3, pre);

        // 17-bit modulus; 1229 has six set bits -> 3+11+6 ops
        pre = enable_cnt;
        begin_run(5792, 1229, 11, 72639, 17, big_r2, 1'b0);
        wait_done("t5", big_y, 20, pre);

        // same run disturbed by a second start and a changed base
        pre = enable_cnt;
        begin_run(5792, 1229, 11, 72639, 17, big_r2, 1'b0);
        repeat (30) @(negedge clk);
        base = 123; exp = 7; start_p = 1'b1;
        @(negedge clk);
        start_p = 1'b0;
        wait_done("t6", big_y, 20, pre);

        // exp_size 200 clamps to 32: 2^3 mod 13 = 8, 3+32+2 ops
        pre = enable_cnt;
        begin_run(2, 3, 200, 13, 4, 9, 1'b0);
        wait_done("t7", 8, 37, pre);

        // abort while the multiplier is working
        ds = done_seen;
        begin_run(5792, 1229, 11, 72639, 17, big_r2, 1'b0);
        n = 0;
        while (!mm_enable_p && n < 50) begin @(negedge clk); n++; end
        chk("ab_issue_seen", 64'(mm_enable_p), 64'd1);
        @(negedge clk);
        abort_p = 1'b1;
        @(negedge clk);
        abort_p = 1'b0;
        chk("ab_busy_drain", 64'(busy), 64'd1);
        n = 0;
        while (!mm_done_p && n < 50) begin @(negedge clk); n++; end
        chk("ab_mm_done_seen", 64'(mm_done_p), 64'd1);
        chk("ab_busy_at_done", 64'(busy), 64'd1);
        @(negedge clk);
        chk("ab_busy_low", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        chk("ab_no_irq", 64'(done_seen - ds), 64'd0);
        chk("ab_y_kept", 64'(y), 64'd8);

        // a run after the abort
        pre = enable_cnt;
        begin_run(2, 10, 4, 13, 4, 9, 1'b0);
        wait_done("t8", 10, 9, pre);

        // reset in the middle of a run
        begin_run(5792, 1229, 11, 72639, 17, big_r2, 1'b0);
        repeat (12) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_y", 64'(y), 64'd0);
        chk("mr_en", 64'(mm_enable_p), 64'd0);
        chk("mr_mm_a", 64'(mm_a), 64'd0);
        chk("mr_mm_m", 64'(mm_m), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pre = enable_cnt;
        begin_run(2, 1, 1, 13, 4, 9, 1'b0);
        wait_done("t9", 2, 5, pre);

        // abort alone in IDLE does nothing
        @(negedge clk);
        abort_p = 1'b1;
        @(negedge clk);
        abort_p = 1'b0;
        chk("idle_abort_busy", 64'(busy), 64'd0);
        chk("idle_abort_y", 64'(y), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
